fp_addsub_wb_queue: RTL and testbench

- Result-side buffer directly downstream of the pipelined FP add/sub unit. Captures each completed result (result word, rd, reg_write, FP_reg_write) into a small FIFO and presents it to the writeback arbiter over a valid/ready handshake.
- Drives the add/sub unit's pipeline enable so no result is ever dropped or double-captured.
- Exposes per-entry rd/write-enable vectors so hazard logic can treat queued results as in-flight.

---
 rtl/fp_addsub_wb_queue_pkg.sv | 26 ++
 rtl/fp_addsub_wb_queue_fifo.sv | 112 +++++++++++
 rtl/fp_addsub_wb_queue.sv | 117 +++++++++++
 tb/tb_fp_addsub_wb_queue.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_addsub_wb_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fp_addsub_wb_queue_pkg
// Purpose : Shared definitions for the FP add/sub writeback queue: default
//           queue depth, result width, register-index width and the layout
//           of one queued writeback entry.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package fp_addsub_wb_queue_pkg;

    localparam int FP_ADDSUB_WBQ_DEPTH = 4;
    localparam int FP_WB_DATA_W        = 32;
    localparam int FP_RD_W             = 5;

    // One completed add/sub result waiting for the writeback arbiter.
    // Storage packs the fields in this same order (data in the MSBs).
    typedef struct packed {
        logic [FP_WB_DATA_W-1:0] data;
        logic [FP_RD_W-1:0]      rd;
        logic                    reg_write;
        logic                    fp_reg_write;
    } fp_wb_entry_t;

endpackage : fp_addsub_wb_queue_pkg
`default_nettype wire

// File: rtl/fp_addsub_wb_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fp_addsub_wb_queue_fifo
// Purpose : Generic pointer/count FIFO used as the writeback result store.
//           Supports simultaneous push and pop in any state (including full
//           and empty), a synchronous flush, and exposes the low SLOT_W bits
//           of every slot plus a per-slot occupancy mask.
// Ports   : clk, rst (async, active-high)
//           flush_i        - drop all entries at the next edge
//           push_i/wdata_i - write one entry
//           pop_i          - retire the head entry
//           head_o         - head slot contents (valid only when count_o!=0)
//           count_o        - occupied entries
//           slots_o        - low SLOT_W bits of each slot, slot i at [i*SLOT_W]
//           slot_valid_o   - slot i currently holds a queued entry
// Revision: 1.0 - initial release
// ============================================================================
module fp_addsub_wb_queue_fifo
    import fp_addsub_wb_queue_pkg::*;
#(
    parameter int DEPTH  = FP_ADDSUB_WBQ_DEPTH,
    parameter int WIDTH  = 39,
    parameter int SLOT_W = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  logic [WIDTH-1:0]          wdata_i,
    input  logic                      pop_i,
    output logic [WIDTH-1:0]          head_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [DEPTH*SLOT_W-1:0]   slots_o,
    output logic [DEPTH-1:0]          slot_valid_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q,  count_d;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (count_q == c_CNT_W'(DEPTH));
    assign w_empty   = (count_q == '0);
    assign w_do_pop  = pop_i & ~w_empty;
    // A pop in the same cycle frees the slot the push is about to use.
    assign w_do_push = push_i & (~w_full | w_do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                count_d = count_q + c_CNT_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                count_d = count_q - c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        localparam logic [c_PTR_W-1:0] c_IDX = c_PTR_W'(i);
        logic [c_PTR_W-1:0] w_off;

        // Distance from the head, modulo DEPTH; occupied if inside the window.
        assign w_off           = c_IDX - rd_ptr_q;
        assign slot_valid_o[i] = ({1'b0, w_off} < count_q);
        assign slots_o[i*SLOT_W +: SLOT_W] = mem_q[i][SLOT_W-1:0];
    end

endmodule : fp_addsub_wb_queue_fifo
`default_nettype wire

// File: rtl/fp_addsub_wb_queue.sv
`default_nettype none
// ============================================================================
// Module  : fp_addsub_wb_queue
// Purpose : Result buffer between the pipelined FP add/sub unit and the
//           writeback arbiter. Captures each completed result into a small
//           FIFO, offers the head over valid/ready, throttles the unit's
//           pipeline enable so no result is dropped or captured twice, and
//           publishes per-entry rd / write-enable vectors for hazard logic.
// Ports   : clk, rst (async, active-high), flush_i
//           res_*_i            - add/sub output stage (valid, data, rd, enables)
//           unit_en_o          - pipeline enable back to the add/sub unit
//           wb_*_o, wb_ready_i - head entry handshake toward writeback
//           q_rd_o             - rd of every slot, slot i at [i*5 +: 5]
//           q_reg_write_o      - per-slot integer write enable (occupied only)
//           q_fp_reg_write_o   - per-slot FP write enable (occupied only)
//           count_o            - occupied entries
// Revision: 1.0 - initial release
// ============================================================================
module fp_addsub_wb_queue
    import fp_addsub_wb_queue_pkg::*;
#(
    parameter int DEPTH  = FP_ADDSUB_WBQ_DEPTH,
    parameter int DATA_W = FP_WB_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       res_valid_i,
    input  logic [DATA_W-1:0]          res_data_i,
    input  logic [FP_RD_W-1:0]         res_rd_i,
    input  logic                       res_reg_write_i,
    input  logic                       res_fp_reg_write_i,
    output logic                       unit_en_o,
    output logic                       wb_valid_o,
    output logic [DATA_W-1:0]          wb_data_o,
    output logic [FP_RD_W-1:0]         wb_rd_o,
    output logic                       wb_reg_write_o,
    output logic                       wb_fp_reg_write_o,
    input  logic                       wb_ready_i,
    output logic [FP_RD_W*DEPTH-1:0]   q_rd_o,
    output logic [DEPTH-1:0]           q_reg_write_o,
    output logic [DEPTH-1:0]           q_fp_reg_write_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam int c_TAG_W = FP_RD_W + 2;
    localparam int c_ENT_W = DATA_W + c_TAG_W;

    logic                     en_q, en_d;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_full;
    logic [c_CNT_W-1:0]       w_free;
    logic [c_ENT_W-1:0]       w_wdata;
    logic [c_ENT_W-1:0]       w_head;
    logic [DEPTH*c_TAG_W-1:0] w_tags;
    logic [DEPTH-1:0]         w_slot_valid;

    // en_q remembers whether the unit advanced at the last edge. If it was
    // frozen, the result on res_* is the one already captured, so it must
    // not be pushed again.
    assign w_push = res_valid_i & en_q;
    assign w_pop  = wb_valid_o & wb_ready_i;

    assign w_wdata = {res_data_i, res_rd_i, res_reg_write_i, res_fp_reg_write_i};

    fp_addsub_wb_queue_fifo #(
        .DEPTH  (DEPTH),
        .WIDTH  (c_ENT_W),
        .SLOT_W (c_TAG_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .push_i       (w_push),
        .wdata_i      (w_wdata),
        .pop_i        (w_pop),
        .head_o       (w_head),
        .count_o      (count_o),
        .slots_o      (w_tags),
        .slot_valid_o (w_slot_valid)
    );

    assign wb_valid_o = (count_o != '0);
    assign w_full     = (count_o == c_CNT_W'(DEPTH));
    assign {wb_data_o, wb_rd_o, wb_reg_write_o, wb_fp_reg_write_o} = w_head;

    // Keep one slot in reserve for the result the unit may deliver at the
    // next edge. Pop is left out on purpose so wb_ready_i never reaches
    // unit_en_o combinationally; flush is left out for the same reason.
    assign w_free    = c_CNT_W'(DEPTH) - count_o;
    assign unit_en_o = (w_free >= c_CNT_W'(2)) |
                       ((w_free == c_CNT_W'(1)) & ~w_push);

    assign en_d = unit_en_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q <= 1'b1;
        end else begin
            en_q <= en_d;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_haz
        assign q_rd_o[i*FP_RD_W +: FP_RD_W] = w_tags[i*c_TAG_W + 2 +: FP_RD_W];
        assign q_reg_write_o[i]    = w_tags[i*c_TAG_W + 1] & w_slot_valid[i];
        assign q_fp_reg_write_o[i] = w_tags[i*c_TAG_W]     & w_slot_valid[i];
    end

    a_no_push_when_full : assert property (
        @(posedge clk) disable iff (rst) !(w_push && w_full && !w_pop)
    );

endmodule : fp_addsub_wb_queue
`default_nettype wire

// File: tb/tb_fp_addsub_wb_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp_addsub_wb_queue
// Purpose : Self-checking bench for fp_addsub_wb_queue. A queue-based model
//           of the buffer tracks expected contents, head slot position and
//           the previous-cycle unit enable; scenario tasks compare DUT
//           outputs against it and against hand-derived constants.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fp_addsub_wb_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush_i;
    logic                res_valid_i;
    logic [DW-1:0]       res_data_i;
    logic [4:0]          res_rd_i;
    logic                res_reg_write_i;
    logic                res_fp_reg_write_i;
    logic                unit_en_o;
    logic                wb_valid_o;
    logic [DW-1:0]       wb_data_o;
    logic [4:0]          wb_rd_o;
    logic                wb_reg_write_o;
    logic                wb_fp_reg_write_o;
    logic                wb_ready_i;
    logic [5*DEPTH-1:0]  q_rd_o;
    logic [DEPTH-1:0]    q_reg_write_o;
    logic [DEPTH-1:0]    q_fp_reg_write_o;
    logic [2:0]          count_o;

    fp_addsub_wb_queue #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush_i            (flush_i),
        .res_valid_i        (res_valid_i),
        .res_data_i         (res_data_i),
        .res_rd_i           (res_rd_i),
        .res_reg_write_i    (res_reg_write_i),
        .res_fp_reg_write_i (res_fp_reg_write_i),
        .unit_en_o          (unit_en_o),
        .wb_valid_o         (wb_valid_o),
        .wb_data_o          (wb_data_o),
        .wb_rd_o            (wb_rd_o),
        .wb_reg_write_o     (wb_reg_write_o),
        .wb_fp_reg_write_o  (wb_fp_reg_write_o),
        .wb_ready_i         (wb_ready_i),
        .q_rd_o             (q_rd_o),
        .q_reg_write_o      (q_reg_write_o),
        .q_fp_reg_write_o   (q_fp_reg_write_o),
        .count_o            (count_o)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic [4:0]    rd;
        logic          rw;
        logic          fw;
    } ent_t;

    ent_t mq[$];
    int   mhead = 0;   // slot index of the oldest entry
    bit   men   = 1'b1; // unit enable seen at the previous edge

    function automatic bit m_en(input bit rv);
        int free;
        bit push;
        free = DEPTH - mq.size();
        push = rv & men;
        return (free >= 2) || (free == 1 && !push);
    endfunction

    task automatic drive(input bit rv, input logic [DW-1:0] d, input logic [4:0] rd,
                         input bit rw, input bit fw, input bit rdy, input bit fl);
        res_valid_i        = rv;
        res_data_i         = d;
        res_rd_i           = rd;
        res_reg_write_i    = rw;
        res_fp_reg_write_i = fw;
        wb_ready_i         = rdy;
        flush_i            = fl;
        #1;
    endtask

    task automatic tick();
        bit   push, pop, en;
        ent_t e;
        en   = m_en(res_valid_i);
        push = res_valid_i & men;
        pop  = (mq.size() > 0) && wb_ready_i;
        e.d  = res_data_i;
        e.rd = res_rd_i;
        e.rw = res_reg_write_i;
        e.fw = res_fp_reg_write_i;
        @(posedge clk);
        if (flush_i) begin
            mq.delete();
            mhead = 0;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                mhead = (mhead + 1) % DEPTH;
            end
            if (push) mq.push_back(e);
        end
        men = en;
        #1;
    endtask

    task automatic idle();
        drive(0, '0, '0, 0, 0, 0, 0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle();
        #11;
        n_total++; if (wb_valid_o !== 1'b0) $display("FAIL reset_wb_valid: got %b want 0", wb_valid_o); else n_pass++;
        n_total++; if (count_o !== 3'd0) $display("FAIL reset_count: got %0d want 0", count_o); else n_pass++;
        n_total++; if (unit_en_o !== 1'b1) $display("FAIL reset_unit_en: got %b want 1", unit_en_o); else n_pass++;
        n_total++; if (q_fp_reg_write_o !== 4'b0 || q_reg_write_o !== 4'b0)
            $display("FAIL reset_q_we: got rw=%b fw=%b want 0000/0000", q_reg_write_o, q_fp_reg_write_o); else n_pass++;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        drive(1, 32'h4040_0000, 5'd5, 0, 1, 1, 0);
        tick();
        drive(0, '0, '0, 0, 0, 1, 0);
        n_total++; if (wb_valid_o !== 1'b1) $display("FAIL single_valid: got %b want 1", wb_valid_o); else n_pass++;
        n_total++; if (wb_data_o !== 32'h4040_0000) $display("FAIL single_data: got %h want 40400000", wb_data_o); else n_pass++;
        n_total++; if (wb_rd_o !== 5'd5) $display("FAIL single_rd: got %0d want 5", wb_rd_o); else n_pass++;
        n_total++; if (wb_fp_reg_write_o !== 1'b1 || wb_reg_write_o !== 1'b0)
            $display("FAIL single_we: got rw=%b fw=%b want 0/1", wb_reg_write_o, wb_fp_reg_write_o); else n_pass++;
        n_total++; if (q_fp_reg_write_o !== 4'(1 << mhead))
            $display("FAIL single_q_fw: got %b want %b", q_fp_reg_write_o, 4'(1 << mhead)); else n_pass++;
        tick();
        n_total++; if (wb_valid_o !== 1'b0 || count_o !== 3'd0)
            $display("FAIL single_after: got valid=%b count=%0d want 0/0", wb_valid_o, count_o); else n_pass++;
    endtask

    task automatic test_fill_drain();
        int cur = 1;
        bit en;
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h3f80_0000 + DW'(cur), 5'(cur), cur[0], ~cur[0], 0, 0);
            n_total++; if (unit_en_o !== (i < 3))
                $display("FAIL fill_unit_en[%0d]: got %b want %b", i, unit_en_o, (i < 3)); else n_pass++;
            en = m_en(1'b1);
            tick();
            if (en) cur++;
            n_total++; if (count_o !== 3'((i + 1 > 4) ? 4 : i + 1))
                $display("FAIL fill_count[%0d]: got %0d want %0d", i, count_o, (i + 1 > 4) ? 4 : i + 1); else n_pass++;
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, '0, '0, 0, 0, 1, 0);
            n_total++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'(k + 1) || wb_data_o !== 32'h3f80_0000 + DW'(k + 1))
                $display("FAIL drain[%0d]: got v=%b rd=%0d d=%h want 1/%0d/%h", k, wb_valid_o, wb_rd_o, wb_data_o,
                         k + 1, 32'h3f80_0000 + DW'(k + 1)); else n_pass++;
            tick();
        end
        idle();
        n_total++; if (wb_valid_o !== 1'b0 || count_o !== 3'd0)
            $display("FAIL drain_empty: got v=%b count=%0d want 0/0", wb_valid_o, count_o); else n_pass++;
    endtask

    task automatic test_frozen_hold();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h1000 + DW'(i), 5'(11 + i), 1, 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'hC000_0000, 5'd14, 0, 1, 0, 0);
            n_total++; if (unit_en_o !== 1'b0) $display("FAIL hold_unit_en[%0d]: got %b want 0", i, unit_en_o); else n_pass++;
            tick();
        end
        n_total++; if (count_o !== 3'd4) $display("FAIL hold_count: got %0d want 4", count_o); else n_pass++;
        drive(0, '0, '0, 0, 0, 1, 0);
        n_total++; if (wb_rd_o !== 5'd11) $display("FAIL hold_head: got %0d want 11", wb_rd_o); else n_pass++;
        tick();
        idle();
        n_total++; if (unit_en_o !== 1'b1 || count_o !== 3'd3)
            $display("FAIL reopen: got en=%b count=%0d want 1/3", unit_en_o, count_o); else n_pass++;
        tick();
        drive(1, 32'hABCD_0015, 5'd15, 1, 1, 1, 0);
        n_total++; if (unit_en_o !== 1'b0 || wb_rd_o !== 5'd12)
            $display("FAIL pushpop_pre: got en=%b rd=%0d want 0/12", unit_en_o, wb_rd_o); else n_pass++;
        tick();
        drive(0, '0, '0, 0, 0, 1, 0);
        n_total++; if (count_o !== 3'd3 || wb_rd_o !== 5'd13)
            $display("FAIL pushpop_post: got count=%0d rd=%0d want 3/13", count_o, wb_rd_o); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            drive(0, '0, '0, 0, 0, 1, 0);
            n_total++; if (wb_rd_o !== 5'(13 + k)) $display("FAIL hold_drain[%0d]: got %0d want %0d", k, wb_rd_o, 13 + k); else n_pass++;
            tick();
        end
        n_total++; if (count_o !== 3'd0) $display("FAIL hold_empty: got %0d want 0", count_o); else n_pass++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h2000 + DW'(i), 5'(20 + i), 0, 1, 0, 0);
            tick();
        end
        drive(1, 32'h2003, 5'd23, 0, 1, 1, 1);
        n_total++; if (count_o !== 3'd3) $display("FAIL flush_pre_count: got %0d want 3", count_o); else n_pass++;
        tick();
        idle();
        n_total++; if (count_o !== 3'd0 || wb_valid_o !== 1'b0 || q_fp_reg_write_o !== 4'b0)
            $display("FAIL flush_post: got count=%0d v=%b qfw=%b want 0/0/0000", count_o, wb_valid_o, q_fp_reg_write_o); else n_pass++;
        tick();
        drive(1, 32'h1234_5678, 5'd7, 1, 0, 0, 0);
        tick();
        idle();
        n_total++; if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h1234_5678 || wb_rd_o !== 5'd7 || wb_reg_write_o !== 1'b1)
            $display("FAIL flush_recapture: got v=%b d=%h rd=%0d rw=%b want 1/12345678/7/1",
                     wb_valid_o, wb_data_o, wb_rd_o, wb_reg_write_o); else n_pass++;
        n_total++; if (q_reg_write_o !== 4'b0001) $display("FAIL flush_q_rw: got %b want 0001", q_reg_write_o); else n_pass++;
        drive(0, '0, '0, 0, 0, 1, 0);
        tick();
    endtask

    task automatic test_random();
        logic [DEPTH-1:0] erw, efw;
        int s;
        for (int c = 0; c < 400; c++) begin
            bit rdy;
            rdy = ((c / 50) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 9) < 7, $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom), 1'($urandom), rdy, $urandom_range(0, 31) == 0);
            n_total++; if (wb_valid_o !== (mq.size() > 0)) $display("FAIL rnd_valid[%0d]: got %b want %b", c, wb_valid_o, mq.size() > 0); else n_pass++;
            n_total++; if (count_o !== 3'(mq.size())) $display("FAIL rnd_count[%0d]: got %0d want %0d", c, count_o, mq.size()); else n_pass++;
            n_total++; if (unit_en_o !== m_en(res_valid_i)) $display("FAIL rnd_unit_en[%0d]: got %b want %b", c, unit_en_o, m_en(res_valid_i)); else n_pass++;
            if (mq.size() > 0) begin
                n_total++; if (wb_data_o !== mq[0].d || wb_rd_o !== mq[0].rd || wb_reg_write_o !== mq[0].rw || wb_fp_reg_write_o !== mq[0].fw)
                    $display("FAIL rnd_head[%0d]: got %h/%0d/%b/%b want %h/%0d/%b/%b", c, wb_data_o, wb_rd_o, wb_reg_write_o,
                             wb_fp_reg_write_o, mq[0].d, mq[0].rd, mq[0].rw, mq[0].fw); else n_pass++;
            end
            erw = '0;
            efw = '0;
            for (int k = 0; k < mq.size(); k++) begin
                s = (mhead + k) % DEPTH;
                erw[s] = mq[k].rw;
                efw[s] = mq[k].fw;
                n_total++; if (q_rd_o[s*5 +: 5] !== mq[k].rd)
                    $display("FAIL rnd_q_rd[%0d] slot %0d: got %0d want %0d", c, s, q_rd_o[s*5 +: 5], mq[k].rd); else n_pass++;
            end
            n_total++; if (q_reg_write_o !== erw || q_fp_reg_write_o !== efw)
                $display("FAIL rnd_q_we[%0d]: got %b/%b want %b/%b", c, q_reg_write_o, q_fp_reg_write_o, erw, efw); else n_pass++;
            tick();
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h5000 + DW'(i), 5'(1 + i), 1, 1, 0, 1'(i == 0));
            tick();
        end
        drive(0, '0, '0, 0, 0, 1, 0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        mq.delete();
        mhead = 0;
        men   = 1'b1;
        n_total++; if (wb_valid_o !== 1'b0 || unit_en_o !== 1'b1 || count_o !== 3'd0)
            $display("FAIL async_rst: got v=%b en=%b count=%0d want 0/1/0", wb_valid_o, unit_en_o, count_o); else n_pass++;
        n_total++; if (q_reg_write_o !== 4'b0 || q_fp_reg_write_o !== 4'b0)
            $display("FAIL async_rst_q: got %b/%b want 0000/0000", q_reg_write_o, q_fp_reg_write_o); else n_pass++;
        #1;
        rst = 1'b0;
        tick();
        n_total++; if (wb_valid_o !== 1'b0 || count_o !== 3'd0)
            $display("FAIL async_after: got v=%b count=%0d want 0/0", wb_valid_o, count_o); else n_pass++;
        drive(1, 32'h7777_0001, 5'd9, 0, 1, 0, 0);
        tick();
        idle();
        n_total++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd9)
            $display("FAIL async_recapture: got v=%b rd=%0d want 1/9", wb_valid_o, wb_rd_o); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_frozen_hold();
        test_flush();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_fp_addsub_wb_queue
`default_nettype wire
